// File: rtl/uartprobe_gpx.sv
// Byte-command UART debug probe: GPO write/set/clear/toggle, GPI read/dump,
// sticky GPI edge capture, driven over valid/ready RX and TX byte streams.
module uartprobe_gpx #(
    parameter int                        GPIO_BYTES = 4,
    parameter logic [8*GPIO_BYTES-1:0]   GPO_RESET  = '0,
    parameter logic [7:0]                ERR_BYTE   = 8'hEE
) (
    input  logic                         clk,
    input  logic                         m_areset,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_data,
    output logic                         rx_ready,
    output logic                         tx_valid,
    output logic [7:0]                   tx_data,
    input  logic                         tx_ready,
    output logic [8*GPIO_BYTES-1:0]      gpo,
    input  logic [8*GPIO_BYTES-1:0]      gpi,
    output logic                         edge_pending
);

    localparam int W = 8 * GPIO_BYTES;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARG1 = 3'd1,
        ARG2 = 3'd2,
        RESP = 3'd3,
        DUMP = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      idx_q, idx_d;
    logic [W-1:0]    gpo_q, gpo_d;
    logic [W-1:0]    snap_q, snap_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            rx_ready_q, rx_ready_d;
    logic [W-1:0]    gs1_q, gs_q, prev_q;
    logic [1:0]      arm_cnt_q;
    logic [W-1:0]    edge_q, edge_d;
    logic            edge_pending_q;
    logic [W-1:0]    clr_s, new_edge_s;
    logic            rx_hs_s, tx_hs_s;

    // Byte idx of v; out-of-range idx yields zero.
    function automatic logic [7:0] get_byte(input logic [W-1:0] v, input logic [7:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < GPIO_BYTES; k++) begin
            r = r | ((idx == 8'(k)) ? v[8*k +: 8] : 8'h00);
        end
        return r;
    endfunction

    // Places m in lane idx; out-of-range idx yields an all-zero mask.
    function automatic logic [W-1:0] lane_mask(input logic [7:0] idx, input logic [7:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < GPIO_BYTES; k++) begin
            r[8*k +: 8] = (idx == 8'(k)) ? m : 8'h00;
        end
        return r;
    endfunction

    assign rx_hs_s = rx_valid & rx_ready_q;
    assign tx_hs_s = tx_valid_q & tx_ready;

    // GPI synchroniser, previous-sample register and edge arming counter.
    always_ff @(posedge clk or posedge m_areset) begin
        if (m_areset) begin
            gs1_q     <= '0;
            gs_q      <= '0;
            prev_q    <= '0;
            arm_cnt_q <= 2'd0;
        end else begin
            gs1_q     <= gpi;
            gs_q      <= gs1_q;
            prev_q    <= gs_q;
            arm_cnt_q <= (arm_cnt_q == 2'd3) ? 2'd3 : arm_cnt_q + 2'd1;
        end
    end

    // Edges are ignored until prev holds a genuinely synchronised sample.
    always_comb begin
        new_edge_s = (arm_cnt_q == 2'd3) ? (gs_q ^ prev_q) : '0;
        edge_d     = (edge_q & ~clr_s) | new_edge_s;
    end

    // Command FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        gpo_d      = gpo_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        clr_s      = '0;
        case (state_q)
            IDLE: begin
                if (rx_hs_s) begin
                    cmd_d = rx_data;
                    case (rx_data)
                        8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09: begin
                            state_d = ARG1;
                        end
                        8'h08: begin
                            state_d    = DUMP;
                            snap_d     = gs_q;
                            cnt_d      = 5'd0;
                            tx_valid_d = 1'b1;
                            tx_data_d  = get_byte(gs_q, 8'h00);
                        end
                        8'h0A: begin
                            state_d    = RESP;
                            tx_valid_d = 1'b1;
                            tx_data_d  = 8'(GPIO_BYTES);
                        end
                        default: begin
                            state_d    = RESP;
                            tx_valid_d = 1'b1;
                            tx_data_d  = ERR_BYTE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            ARG1: begin
                if (rx_hs_s) begin
                    idx_d = rx_data;
                    case (cmd_q)
                        8'h01: begin
                            state_d    = RESP;
                            tx_valid_d = 1'b1;
                            tx_data_d  = rx_data;
                        end
                        8'h02: begin
                            state_d    = RESP;
                            tx_valid_d = 1'b1;
                            tx_data_d  = get_byte(gs_q, rx_data);
                        end
                        8'h03: begin
                            state_d    = RESP;
                            tx_valid_d = 1'b1;
                            tx_data_d  = get_byte(gpo_q, rx_data);
                        end
                        8'h09: begin
                            state_d    = RESP;
                            tx_valid_d = 1'b1;
                            tx_data_d  = get_byte(edge_q, rx_data);
                            clr_s      = lane_mask(rx_data, 8'hFF);
                        end
                        default: begin
                            state_d = ARG2;
                        end
                    endcase
                end else begin
                    state_d = ARG1;
                end
            end
            ARG2: begin
                if (rx_hs_s) begin
                    state_d = IDLE;
                    case (cmd_q)
                        8'h04:   gpo_d = (gpo_q & ~lane_mask(idx_q, 8'hFF)) | lane_mask(idx_q, rx_data);
                        8'h05:   gpo_d = gpo_q | lane_mask(idx_q, rx_data);
                        8'h06:   gpo_d = gpo_q & ~lane_mask(idx_q, rx_data);
                        8'h07:   gpo_d = gpo_q ^ lane_mask(idx_q, rx_data);
                        default: gpo_d = gpo_q;
                    endcase
                end else begin
                    state_d = ARG2;
                end
            end
            RESP: begin
                if (tx_hs_s) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            DUMP: begin
                if (tx_hs_s) begin
                    if (cnt_q == 5'(GPIO_BYTES - 1)) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                    end else begin
                        cnt_d     = cnt_q + 5'd1;
                        tx_data_d = get_byte(snap_q, 8'(cnt_q + 5'd1));
                    end
                end else begin
                    state_d = DUMP;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        rx_ready_d = (state_d == IDLE) || (state_d == ARG1) || (state_d == ARG2);
    end

    // Registered FSM state, datapath and outputs.
    always_ff @(posedge clk or posedge m_areset) begin
        if (m_areset) begin
            state_q        <= IDLE;
            cmd_q          <= 8'h00;
            idx_q          <= 8'h00;
            gpo_q          <= GPO_RESET;
            snap_q         <= '0;
            cnt_q          <= 5'd0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            rx_ready_q     <= 1'b0;
            edge_q         <= '0;
            edge_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            idx_q          <= idx_d;
            gpo_q          <= gpo_d;
            snap_q         <= snap_d;
            cnt_q          <= cnt_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            rx_ready_q     <= rx_ready_d;
            edge_q         <= edge_d;
            edge_pending_q <= |edge_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign gpo          = gpo_q;
    assign edge_pending = edge_pending_q;

endmodule

// File: tb/tb_uartprobe_gpx.sv
// Randomised scoreboard bench for uartprobe_gpx with a byte-level probe model.
module tb_uartprobe_gpx;

    localparam int          GB   = 4;
    localparam logic [31:0] GRST = 32'h00FF0000;

    logic        clk = 1'b0;
    logic        m_areset;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, edge_pending;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] gpo, gpi;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] expq[$];
    logic [7:0] gpo_m[GB];
    logic [7:0] edge_m[GB];
    int  stall_len = 0;
    int  stall_cnt = 0;
    bit  rand_stall = 1'b1;
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;

    uartprobe_gpx #(.GPIO_BYTES(GB), .GPO_RESET(GRST), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .m_areset(m_areset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .gpo(gpo), .gpi(gpi), .edge_pending(edge_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_gpo();
        logic [31:0] r;
        for (int k = 0; k < GB; k++) r[8*k +: 8] = gpo_m[k];
        return r;
    endfunction

    function automatic logic [7:0] gbyte(input logic [31:0] v, input logic [7:0] a);
        return (a < GB) ? 8'(v >> (8 * a)) : 8'h00;
    endfunction

    // tx_ready: stall a configurable number of cycles, then accept one byte.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_ready) begin
                tx_ready  = 1'b0;
                stall_cnt = 0;
                if (rand_stall) stall_len = $urandom_range(0, 3);
            end else if (tx_valid) begin
                if (stall_cnt >= stall_len) tx_ready = 1'b1;
                else stall_cnt++;
            end
        end
    end

    // Monitor: pop the scoreboard on each tx handshake and check hold stability.
    always @(negedge clk) begin
        if (!m_areset) begin
            if (held_v) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held_d});
            if (tx_valid && tx_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, expq.pop_front()});
                end
            end
            held_v <= tx_valid && !tx_ready;
            held_d <= tx_data;
        end else begin
            held_v <= 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_timeout: rx_ready=0 expected 1 for byte %h", b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic set_gpi(input logic [31:0] nv);
        for (int k = 0; k < GB; k++) edge_m[k] = edge_m[k] | 8'((gpi ^ nv) >> (8 * k));
        gpi = nv;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] v);
        logic [7:0] e;
        bit inr;
        inr = (a < GB);
        case (c)
            8'h01, 8'h02, 8'h03, 8'h09: begin
                send_byte(c);
                if (c == 8'h01) e = a;
                else if (c == 8'h02) e = gbyte(gpi, a);
                else if (c == 8'h03) e = inr ? gpo_m[a[1:0]] : 8'h00;
                else begin
                    e = inr ? edge_m[a[1:0]] : 8'h00;
                    if (inr) edge_m[a[1:0]] = 8'h00;
                end
                expq.push_back(e);
                send_byte(a);
            end
            8'h04, 8'h05, 8'h06, 8'h07: begin
                send_byte(c);
                send_byte(a);
                if (inr) begin
                    if (c == 8'h04) gpo_m[a[1:0]] = v;
                    else if (c == 8'h05) gpo_m[a[1:0]] = gpo_m[a[1:0]] | v;
                    else if (c == 8'h06) gpo_m[a[1:0]] = gpo_m[a[1:0]] & ~v;
                    else gpo_m[a[1:0]] = gpo_m[a[1:0]] ^ v;
                end
                send_byte(v);
                check("gpo_update", gpo, pack_gpo());
            end
            8'h08: begin
                for (int k = 0; k < GB; k++) begin
                    e = gbyte(gpi, 8'(k));
                    expq.push_back(e);
                end
                send_byte(c);
            end
            8'h0A: begin
                e = 8'(GB);
                expq.push_back(e);
                send_byte(c);
            end
            default: begin
                e = 8'hEE;
                expq.push_back(e);
                send_byte(c);
            end
        endcase
    endtask

    task automatic drain();
        int t = 0;
        while ((expq.size() != 0 || tx_valid) && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 1000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d bytes outstanding expected 0", expq.size());
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < GB; k++) begin
            gpo_m[k]  = 8'(GRST >> (8 * k));
            edge_m[k] = 8'h00;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c, a, v;
        logic [7:0] tgl_exp[3];
        m_areset = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        gpi      = 32'h13579BDF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_gpo", gpo, GRST);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_edge_pending", {31'd0, edge_pending}, 32'd0);
        @(negedge clk);
        m_areset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("idle_gpo", gpo, GRST);
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("no_spurious_edge", {31'd0, edge_pending}, 32'd0);

        run_cmd(8'h04, 8'h02, 8'h5A);
        check("wr_byte2", gpo, 32'h005A0000);
        run_cmd(8'h03, 8'h02, 8'h00);
        drain();

        tgl_exp[0] = 8'hFF; tgl_exp[1] = 8'h7E; tgl_exp[2] = 8'h81;
        run_cmd(8'h04, 8'h01, 8'hF0);
        run_cmd(8'h05, 8'h01, 8'h0F);
        check("set_byte1", {24'd0, gpo[15:8]}, {24'd0, tgl_exp[0]});
        run_cmd(8'h03, 8'h01, 8'h00);
        run_cmd(8'h06, 8'h01, 8'h81);
        check("clr_byte1", {24'd0, gpo[15:8]}, {24'd0, tgl_exp[1]});
        run_cmd(8'h03, 8'h01, 8'h00);
        run_cmd(8'h07, 8'h01, 8'hFF);
        check("tgl_byte1", {24'd0, gpo[15:8]}, {24'd0, tgl_exp[2]});
        run_cmd(8'h03, 8'h01, 8'h00);
        drain();

        set_gpi(32'hDEADBEEF);
        rand_stall = 1'b0;
        stall_len  = 5;
        run_cmd(8'h08, 8'h00, 8'h00);
        set_gpi(32'h12345678);
        drain();
        rand_stall = 1'b1;

        set_gpi(32'h00000000);
        for (int k = 0; k < GB; k++) run_cmd(8'h09, 8'(k), 8'h00);
        drain();
        check("edges_cleared", {31'd0, edge_pending}, 32'd0);
        gpi[9] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gpi[9] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        edge_m[1] = edge_m[1] | 8'h02;
        check("edge_pending_set", {31'd0, edge_pending}, 32'd1);
        run_cmd(8'h09, 8'h01, 8'h00);
        run_cmd(8'h09, 8'h01, 8'h00);
        drain();
        check("edge_pending_clr", {31'd0, edge_pending}, 32'd0);

        run_cmd(8'h04, 8'h07, 8'hAA);
        run_cmd(8'h02, 8'h09, 8'h00);
        run_cmd(8'h03, 8'hFF, 8'h00);
        run_cmd(8'h09, 8'h04, 8'h00);
        run_cmd(8'h7F, 8'h00, 8'h00);
        run_cmd(8'h0A, 8'h00, 8'h00);
        drain();

        for (int i = 0; i < 160; i++) begin
            if (i % 20 == 0) set_gpi($urandom);
            c = 8'($urandom_range(0, 12));
            if (c == 8'd11) c = 8'($urandom);
            if (c == 8'd12) c = 8'hFF;
            a = 8'($urandom_range(0, 5));
            v = 8'($urandom);
            run_cmd(c, a, v);
        end
        drain();

        send_byte(8'h04);
        send_byte(8'h00);
        @(negedge clk);
        m_areset = 1'b1;
        #1;
        model_reset();
        check("abort_gpo", gpo, GRST);
        check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        m_areset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_gpo_after", gpo, GRST);
        run_cmd(8'h0A, 8'h00, 8'h00);
        run_cmd(8'h03, 8'h02, 8'h00);
        run_cmd(8'h09, 8'h00, 8'h00);
        drain();
        check("scoreboard_empty", expq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
